// File: rtl/alu_flag_writeback.sv
// alu_flag_writeback: one-entry output register behind the 8-bit ALU.
// Holds the result for register-file writeback (valid/ready) and owns the
// architectural {N,Z,C} flags, including carry feedback and branch-condition
// evaluation. Optional macro FLAG_SHADOW_EN adds a 3-bit flag shadow with
// save/restore; without it flag_save/flag_restore are ignored.
module alu_flag_writeback #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic [1:0]       in_op,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic             carry_flag,
    output logic [2:0]       flags,
    input  logic             clc,
    input  logic [2:0]       cond_sel,
    output logic             cond_true,
    input  logic             flag_save,
    input  logic             flag_restore
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // Flag bit positions inside the {N,Z,C} vector
    localparam int FC = 0;
    localparam int FZ = 1;
    localparam int FN = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_q;
    logic             data_load;
    logic             accept;
    logic [2:0]       flags_q, flags_nxt;
    logic             res_z, res_n;
    logic             add_accept;

    // A slot frees up in the same cycle the held result is written back,
    // so a non-stalling consumer sees one result per clock.
    assign in_ready   = (state == EMPTY) || wb_ready;
    assign accept     = in_valid && in_ready;
    assign add_accept = accept && (in_op == OP_ADD);

    // Z/N are derived here rather than taken from the ALU so they always
    // match the value actually captured.
    assign res_z = (in_result == '0);
    assign res_n = in_result[WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next-state and data-load decode for the one-entry buffer
    always_comb begin
        state_nxt = state;
        data_load = 1'b0;
        if (accept) begin
            state_nxt = FULL;
            data_load = 1'b1;
        end else if ((state == FULL) && wb_ready) begin
            state_nxt = EMPTY;
        end
    end

    // Held result; only written on accept so it stays stable through stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         data_q <= '0;
        else if (data_load) data_q <= in_result;
    end

    assign wb_valid = (state == FULL);
    assign wb_data  = data_q;

`ifdef FLAG_SHADOW_EN
    logic [2:0] shadow_q;

    // Shadow captures pre-edge flags, so save+restore together swaps cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         shadow_q <= 3'b000;
        else if (flag_save) shadow_q <= flags_q;
    end
`else
    logic unused_shadow_ctrl;
    assign unused_shadow_ctrl = flag_save ^ flag_restore;
`endif

    // Next flags: op-dependent update, then clc, then restore overrides all
    always_comb begin
        flags_nxt = flags_q;
        if (accept) begin
            case (in_op)
                OP_ADD: begin
                    flags_nxt[FC] = in_carry;
                    flags_nxt[FZ] = res_z;
                    flags_nxt[FN] = res_n;
                end
                OP_AND, OP_OR: begin
                    flags_nxt[FZ] = res_z;
                    flags_nxt[FN] = res_n;
                end
                OP_PASS: flags_nxt = flags_q;
                default: flags_nxt = flags_q;
            endcase
        end
        // An ADD accepted in the same cycle owns the carry
        if (clc && !add_accept) flags_nxt[FC] = 1'b0;
`ifdef FLAG_SHADOW_EN
        if (flag_restore) flags_nxt = shadow_q;
`endif
    end

    // Architectural flag register, independent of writeback stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= 3'b000;
        else        flags_q <= flags_nxt;
    end

    assign flags      = flags_q;
    assign carry_flag = flags_q[FC];

    // Branch condition from committed flags
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[FZ];
            3'b010:  cond_true = !flags_q[FZ];
            3'b011:  cond_true = flags_q[FC];
            3'b100:  cond_true = !flags_q[FC];
            3'b101:  cond_true = flags_q[FN];
            3'b110:  cond_true = !flags_q[FN];
            3'b111:  cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Self-checking bench for alu_flag_writeback: directed test-plan steps then
// randomized traffic, all compared against a transaction-level model.
module tb_alu_flag_writeback;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_result = 8'h00;
    logic       in_carry = 1'b0;
    logic [1:0] in_op = 2'b00;
    logic       wb_valid;
    logic       wb_ready = 1'b0;
    logic [7:0] wb_data;
    logic       carry_flag;
    logic [2:0] flags;
    logic       clc = 1'b0;
    logic [2:0] cond_sel = 3'b000;
    logic       cond_true;
    logic       flag_save = 1'b0;
    logic       flag_restore = 1'b0;

    int passed = 0;
    int total  = 0;

    // Model state: buffer occupancy, held value, and flags as separate bits
    bit       m_full;
    bit [7:0] m_data;
    bit       m_n, m_z, m_c;
    bit       s_n, s_z, s_c;

    alu_flag_writeback #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry), .in_op(in_op),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .carry_flag(carry_flag), .flags(flags),
        .clc(clc), .cond_sel(cond_sel), .cond_true(cond_true),
        .flag_save(flag_save), .flag_restore(flag_restore)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit m_cond(input bit [2:0] sel);
        case (sel)
            3'd0: return 1'b1;
            3'd1: return m_z;
            3'd2: return !m_z;
            3'd3: return m_c;
            3'd4: return !m_c;
            3'd5: return m_n;
            3'd6: return !m_n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_full = 0; m_data = 0;
        m_n = 0; m_z = 0; m_c = 0;
        s_n = 0; s_z = 0; s_c = 0;
    endtask

    // Apply one clock edge of the spec rules to the model
    task automatic model_step();
        bit acc, is_add;
        bit pn, pz, pc;
        pn = m_n; pz = m_z; pc = m_c;
        acc = in_valid && (!m_full || wb_ready);
        is_add = acc && (in_op == 2'd0);
        if (acc) begin
            m_full = 1;
            m_data = in_result;
            if (in_op != 2'd3) begin
                m_z = (in_result == 0);
                m_n = (in_result >= 8'd128);
                if (in_op == 2'd0) m_c = in_carry;
            end
        end else if (m_full && wb_ready) begin
            m_full = 0;
        end
        if (clc && !is_add) m_c = 0;
`ifdef FLAG_SHADOW_EN
        if (flag_restore) begin m_n = s_n; m_z = s_z; m_c = s_c; end
        if (flag_save)    begin s_n = pn;  s_z = pz;  s_c = pc;  end
`endif
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ":in_ready"},   32'(in_ready),   32'(!m_full || wb_ready));
        check({ctx, ":wb_valid"},   32'(wb_valid),   32'(m_full));
        check({ctx, ":wb_data"},    32'(wb_data),    32'(m_data));
        check({ctx, ":flags"},      32'(flags),      32'({m_n, m_z, m_c}));
        check({ctx, ":carry_flag"}, 32'(carry_flag), 32'(m_c));
        check({ctx, ":cond_true"},  32'(cond_true),  32'(m_cond(cond_sel)));
    endtask

    // Inputs are set in the low phase; check, advance model, clock, return at negedge
    task automatic cyc(input string ctx);
        #1;
        check_all(ctx);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        check("reset_cond000", 32'(cond_true), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 0x00 with carry: Z and C set
        wb_ready = 1; in_valid = 1; in_op = 2'd0; in_result = 8'h00; in_carry = 1;
        cyc("add0");
        in_valid = 0;
        check("add0_wb_valid", 32'(wb_valid), 32'd1);
        check("add0_wb_data",  32'(wb_data),  32'h00);
        check("add0_flags",    32'(flags),    32'b011);
        check("add0_carry",    32'(carry_flag), 32'd1);
        cyc("drain0");
        check("drain0_wb_valid", 32'(wb_valid), 32'd0);

        // AND 0x80: N set, C held
        in_valid = 1; in_op = 2'd1; in_result = 8'h80; in_carry = 0;
        cyc("and80");
        in_valid = 0;
        check("and80_flags", 32'(flags), 32'b101);
        cond_sel = 3'b101; #1;
        check("cond_N", 32'(cond_true), 32'd1);
        cond_sel = 3'b100; #1;
        check("cond_notC", 32'(cond_true), 32'd0);
        cyc("idle");

        // Stall: hold 0x12 while 0x34 is offered
        wb_ready = 0; in_valid = 1; in_op = 2'd3; in_result = 8'h12;
        cyc("stall_acc");
        in_result = 8'h34;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc("stall_hold");
            check("stall_wb_data", 32'(wb_data), 32'h12);
        end
        wb_ready = 1;
        cyc("stall_release");
        check("release_wb_data",  32'(wb_data),  32'h34);
        check("release_wb_valid", 32'(wb_valid), 32'd1);

        // Back-to-back with no bubbles
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_op = 2'd2; in_result = 8'(i);
            cyc("b2b");
            check("b2b_wb_data",  32'(wb_data),  32'(i));
            check("b2b_wb_valid", 32'(wb_valid), 32'd1);
        end
        in_valid = 0;
        cyc("b2b_drain");

        // clc loses to same-cycle ADD carry, then clears alone
        in_valid = 1; in_op = 2'd0; in_result = 8'h05; in_carry = 1; clc = 1;
        cyc("clc_add");
        check("clc_add_carry", 32'(carry_flag), 32'd1);
        in_valid = 0;
        cyc("clc_alone");
        clc = 0;
        check("clc_alone_carry", 32'(carry_flag), 32'd0);

        // Shadow save/restore (model ignores these when the feature is off)
        in_valid = 1; in_op = 2'd0; in_result = 8'h80; in_carry = 1;
        cyc("set101");
        in_valid = 0; flag_save = 1;
        cyc("save");
        flag_save = 0; in_valid = 1; in_op = 2'd0; in_result = 8'h01; in_carry = 0;
        cyc("add01");
        in_valid = 0;
        check("add01_flags", 32'(flags), 32'b000);
        flag_restore = 1;
        cyc("restore");
        flag_restore = 0;
`ifdef FLAG_SHADOW_EN
        check("restore_flags", 32'(flags), 32'b101);
`else
        check("no_restore_flags", 32'(flags), 32'b000);
`endif

        // Mid-operation reset while FULL
        wb_ready = 0; in_valid = 1; in_op = 2'd0; in_result = 8'hAA; in_carry = 1;
        cyc("pre_rst");
        in_valid = 0;
        check("pre_rst_full", 32'(wb_valid), 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_flags",    32'(flags),    32'b000);
        check("rst_wb_data",  32'(wb_data),  32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            wb_ready     = ($urandom_range(0, 2) != 0);
            in_op        = 2'($urandom_range(0, 3));
            in_result    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            in_carry     = 1'($urandom);
            clc          = ($urandom_range(0, 7) == 0);
            flag_save    = ($urandom_range(0, 7) == 0);
            flag_restore = ($urandom_range(0, 7) == 0);
            cond_sel     = 3'($urandom);
            cyc("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
